// File: rtl/link_frame_builder_pkg.sv
// Shared constants, FSM state encoding and link word formats for the frame builder.
// Latency: none (package only).
// Backpressure: n/a.
package link_frame_builder_pkg;

   localparam int         MEM_W        = 54;
   localparam int         LINK_W       = 64;
   localparam logic [7:0] HDR_MARK_DEF = 8'hA5;
   localparam logic [7:0] TRL_MARK_DEF = 8'h5A;
   localparam logic [1:0] PAY_TAG      = 2'b01;

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;

   typedef struct packed {
      logic [7:0]  mark;
      logic [4:0]  rsvd;
      logic [2:0]  bx;
      logic [47:0] zero;
   } hdr_t;

   typedef struct packed {
      logic [1:0]       tag;
      logic [7:0]       rsvd;
      logic [MEM_W-1:0] dat;
   } pay_t;

   typedef struct packed {
      logic [7:0]  mark;
      logic        truncated;
      logic        overflow;
      logic [2:0]  rsvd;
      logic [2:0]  bx;
      logic [39:0] zero;
      logic [7:0]  count;
   } trl_t;

   function automatic logic [LINK_W-1:0] mk_hdr(input logic [7:0] mark, input logic [2:0] bx);
      hdr_t h;
      h = '{mark: mark, rsvd: '0, bx: bx, zero: '0};
      return h;
   endfunction

   function automatic logic [LINK_W-1:0] mk_pay(input logic [MEM_W-1:0] dat);
      pay_t p;
      p = '{tag: PAY_TAG, rsvd: '0, dat: dat};
      return p;
   endfunction

   function automatic logic [LINK_W-1:0] mk_trl(input logic [7:0] mark, input logic trunc,
                                                input logic ovf, input logic [2:0] bx,
                                                input logic [7:0] cnt);
      trl_t t;
      t = '{mark: mark, truncated: trunc, overflow: ovf, rsvd: '0, bx: bx, zero: '0, count: cnt};
      return t;
   endfunction

endpackage

// File: rtl/link_frame_builder_if.sv
// Bundles the merge-stage input stream, the event strobe and the framed link output.
// Latency: none (wiring only).
// Backpressure: link_ready from the consumer; the input stream has none (drops on full).
interface link_frame_builder_if;
   import link_frame_builder_pkg::*;

   logic              new_event;
   logic [2:0]        BX;
   logic [MEM_W-1:0]  mem_dat_stream;
   logic              valid;
   logic              none;
   logic              link_ready;
   logic [LINK_W-1:0] link_dat;
   logic              link_valid;
   logic              frame_done;

   modport master (
      output new_event, BX, mem_dat_stream, valid, none, link_ready,
      input  link_dat, link_valid, frame_done
   );

   modport slave (
      input  new_event, BX, mem_dat_stream, valid, none, link_ready,
      output link_dat, link_valid, frame_done
   );
endinterface

// File: rtl/link_frame_builder_fifo.sv
// Single-clock payload buffer with full/empty flags and a synchronous clear.
// Latency: a pushed word is readable at pop_dat the cycle after the push.
// Backpressure: caller must not push when full (unless popping) nor pop when empty.
module link_fifo #(
   parameter int WIDTH = 54,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_dat = mem[rd_ptr[AW-1:0]];

   // Pointer update; clear and reset both empty the buffer.
   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
   end
endmodule

// File: rtl/link_frame_builder.sv
// Frames merged memory words as header / payload* / trailer on a 64-bit link.
// Latency: buffered word reaches link_dat one cycle after its write when the buffer is empty.
// Backpressure: link_ready stalls the registered output; input words drop when the buffer is full.
module link_frame_builder
   import link_frame_builder_pkg::*;
#(
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] HDR_MARK   = HDR_MARK_DEF,
   parameter logic [7:0] TRL_MARK   = TRL_MARK_DEF
) (
   input logic                 clk,
   input logic                 reset,
   link_frame_builder_if.slave bus
);
   state_t            state, state_nxt;
   logic              trl_loaded, pending, event_active, truncated, overflow, out_pay;
   logic [7:0]        count, cnt_eff;
   logic [1:0]        holdoff;
   logic [2:0]        bx_latched, frame_bx, hdr_bx;
   logic              fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_clr;
   logic [MEM_W-1:0]  fifo_dat;
   logic              xfer, slot_free, trunc, ovf_now, cnt_inc;
   logic              load, load_pay, trl_load, hdr_load, evt_end;
   logic [LINK_W-1:0] load_dat, trl_word;

   assign xfer      = bus.link_valid && bus.link_ready;
   assign slot_free = !bus.link_valid || bus.link_ready;
   // A new event while the frame is still open cuts it short.
   assign trunc     = bus.new_event && (state == HEADER || state == PAYLOAD);
   assign fifo_clr  = trunc;
   assign fifo_push = bus.valid && event_active && !fifo_clr && (!fifo_full || fifo_pop);
   assign ovf_now   = bus.valid && event_active && !fifo_clr && fifo_full && !fifo_pop;
   // The payload leaving this cycle must already be in the trailer count.
   assign cnt_inc   = xfer && out_pay;
   assign cnt_eff   = (cnt_inc && count != 8'hFF) ? count + 8'd1 : count;
   assign hdr_bx    = bus.new_event ? bus.BX : bx_latched;
   assign trl_word  = mk_trl(TRL_MARK, truncated | trunc, overflow, frame_bx, cnt_eff);
   assign bus.frame_done = (state == TRAILER) && trl_loaded && xfer;

   link_fifo #(.WIDTH(MEM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .clr      (fifo_clr),
      .push     (fifo_push),
      .push_dat (bus.mem_dat_stream),
      .pop      (fifo_pop),
      .pop_dat  (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Next state and the choice of word to load into the output register.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      load_pay  = 1'b0;
      load_dat  = '0;
      fifo_pop  = 1'b0;
      trl_load  = 1'b0;
      hdr_load  = 1'b0;
      evt_end   = 1'b0;
      unique case (state)
         IDLE: if (bus.new_event || pending) begin
            hdr_load  = 1'b1;
            state_nxt = HEADER;
         end
         HEADER: if (trunc) state_nxt = TRAILER;
         else if (xfer) begin
            state_nxt = PAYLOAD;
            fifo_pop  = !fifo_empty;
         end
         PAYLOAD: if (trunc) state_nxt = TRAILER;
         else if (slot_free) begin
            if (!fifo_empty) fifo_pop = 1'b1;
            else if (bus.none && holdoff == 2'd3) begin
               trl_load  = 1'b1;
               evt_end   = 1'b1;
               state_nxt = TRAILER;
            end
         end
         TRAILER: if (!trl_loaded) trl_load = slot_free;
         else if (xfer) begin
            if (pending || bus.new_event) begin
               hdr_load  = 1'b1;
               state_nxt = HEADER;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (trunc && slot_free) trl_load = 1'b1;
      if (hdr_load) begin
         load     = 1'b1;
         load_dat = mk_hdr(HDR_MARK, hdr_bx);
      end else if (trl_load) begin
         load     = 1'b1;
         load_dat = trl_word;
      end else if (fifo_pop) begin
         load     = 1'b1;
         load_pay = 1'b1;
         load_dat = mk_pay(fifo_dat);
      end
   end

   // State register, plus whether the trailer already sits in the output register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         trl_loaded <= 1'b0;
      end else begin
         state      <= state_nxt;
         trl_loaded <= (state_nxt == TRAILER) && (trl_loaded || trl_load);
      end
   end

   // Per-event and per-frame bookkeeping; frame flags restart when a header is loaded.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bx_latched   <= '0;
         frame_bx     <= '0;
         event_active <= 1'b0;
         holdoff      <= '0;
         pending      <= 1'b0;
         truncated    <= 1'b0;
         overflow     <= 1'b0;
         count        <= '0;
      end else begin
         if (bus.new_event) bx_latched <= bus.BX;
         if (hdr_load)      frame_bx   <= hdr_bx;
         if (bus.new_event)  event_active <= 1'b1;
         else if (evt_end)   event_active <= 1'b0;
         if (bus.new_event)       holdoff <= '0;
         else if (holdoff != 2'd3) holdoff <= holdoff + 2'd1;
         pending   <= !hdr_load && (pending || bus.new_event);
         truncated <= !hdr_load && (truncated || trunc);
         overflow  <= hdr_load ? ovf_now : (overflow || ovf_now);
         count     <= hdr_load ? '0 : cnt_eff;
      end
   end

   // Registered link output; data holds while stalled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bus.link_valid <= 1'b0;
         bus.link_dat   <= '0;
         out_pay        <= 1'b0;
      end else if (load) begin
         bus.link_valid <= 1'b1;
         bus.link_dat   <= load_dat;
         out_pay        <= load_pay;
      end else if (slot_free) begin
         bus.link_valid <= 1'b0;
         out_pay        <= 1'b0;
      end
   end
endmodule

// File: tb/tb_link_frame_builder.sv
// Directed bench for link_frame_builder: reset, normal frames, stall, overflow, truncation, empty frame.
// Latency: n/a.
// Backpressure: link_ready driven per scenario.
module tb_link_frame_builder;
   logic clk;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   logic [63:0] rx_q[$];
   logic [63:0] exp_q[$];

   link_frame_builder_if bus ();

   link_frame_builder #(.FIFO_DEPTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Collect transferred words and frame_done pulses away from the active edge.
   always @(negedge clk) begin
      if (bus.link_valid && bus.link_ready) rx_q.push_back(bus.link_dat);
      if (bus.frame_done) done_cnt++;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [53:0] wd(input int tst, input int k);
      return {6'(tst), 16'hC0DE, 32'(k)};
   endfunction

   function automatic logic [63:0] e_hdr(input logic [2:0] bx);
      return {8'hA5, 5'b0, bx, 48'b0};
   endfunction

   function automatic logic [63:0] e_pay(input logic [53:0] d);
      return {2'b01, 8'b0, d};
   endfunction

   function automatic logic [63:0] e_trl(input logic t, input logic o, input logic [2:0] bx,
                                         input logic [7:0] c);
      return {8'h5A, t, o, 3'b0, bx, 40'b0, c};
   endfunction

   task automatic begin_frame(input logic [2:0] bx);
      bus.new_event = 1'b1;
      bus.BX        = bx;
      bus.none      = 1'b0;
      step();
      bus.new_event = 1'b0;
   endtask

   task automatic send_word(input logic [53:0] d);
      bus.valid          = 1'b1;
      bus.mem_dat_stream = d;
      step();
      bus.valid          = 1'b0;
   endtask

   task automatic expect_frames(input string tag, input int nfr, input int rx0, input int dn0);
      for (int k = 0; k < 400 && (done_cnt - dn0) < nfr; k++) step();
      repeat (3) step();
      check_val({tag, "_frames"}, done_cnt - dn0, nfr);
      check_val({tag, "_len"}, rx_q.size() - rx0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check_val($sformatf("%s_w%0d", tag, i),
                   (rx0 + i < rx_q.size()) ? rx_q[rx0 + i] : 64'hx, exp_q[i]);
   endtask

   initial begin
      int rx0;
      int dn0;
      reset              = 1'b0;
      bus.new_event      = 1'b1;
      bus.BX             = 3'd7;
      bus.mem_dat_stream = '0;
      bus.valid          = 1'b0;
      bus.none           = 1'b0;
      bus.link_ready     = 1'b1;
      repeat (3) step();
      check_val("rst_link_valid", bus.link_valid, 0);
      check_val("rst_link_dat", bus.link_dat, 0);
      check_val("rst_frame_done", bus.frame_done, 0);
      check_val("rst_fifo_empty", dut.u_fifo.empty, 1);
      reset         = 1'b1;
      bus.new_event = 1'b0;
      repeat (2) step();
      check_val("rst_overrides_evt", bus.link_valid, 0);
      rx0 = rx_q.size();
      for (int k = 0; k < 3; k++) send_word(wd(0, k));
      repeat (4) step();
      check_val("pre_evt_ignored", rx_q.size() - rx0, 0);

      // Basic frame: BX=3, three words.
      exp_q.delete(); rx0 = rx_q.size(); dn0 = done_cnt;
      begin_frame(3'd3);
      for (int k = 0; k < 3; k++) send_word(wd(1, k));
      bus.none = 1'b1;
      exp_q.push_back(e_hdr(3'd3));
      for (int k = 0; k < 3; k++) exp_q.push_back(e_pay(wd(1, k)));
      exp_q.push_back(e_trl(1'b0, 1'b0, 3'd3, 8'd3));
      expect_frames("basic", 1, rx0, dn0);

      // Five-cycle stall mid-payload: second payload must hold.
      exp_q.delete(); rx0 = rx_q.size(); dn0 = done_cnt;
      begin_frame(3'd1);
      for (int cyc = 0; cyc < 12; cyc++) begin
         bus.valid          = (cyc < 6);
         bus.mem_dat_stream = wd(2, cyc);
         bus.link_ready     = !(cyc >= 3 && cyc < 8);
         if (cyc >= 3 && cyc < 8) begin
            check_val($sformatf("stall_vld%0d", cyc), bus.link_valid, 1);
            check_val($sformatf("stall_dat%0d", cyc), bus.link_dat, e_pay(wd(2, 1)));
         end
         step();
      end
      bus.valid = 1'b0;
      bus.none  = 1'b1;
      exp_q.push_back(e_hdr(3'd1));
      for (int k = 0; k < 6; k++) exp_q.push_back(e_pay(wd(2, k)));
      exp_q.push_back(e_trl(1'b0, 1'b0, 3'd1, 8'd6));
      expect_frames("stall", 1, rx0, dn0);

      // Overflow: 20 words into a 16-deep buffer with the link blocked.
      exp_q.delete(); rx0 = rx_q.size(); dn0 = done_cnt;
      bus.link_ready = 1'b0;
      begin_frame(3'd2);
      for (int k = 0; k < 20; k++) send_word(wd(3, k));
      bus.none       = 1'b1;
      bus.link_ready = 1'b1;
      exp_q.push_back(e_hdr(3'd2));
      for (int k = 0; k < 16; k++) exp_q.push_back(e_pay(wd(3, k)));
      exp_q.push_back(e_trl(1'b0, 1'b1, 3'd2, 8'd16));
      expect_frames("ovf", 1, rx0, dn0);

      // Truncation: second event after two payloads have gone out.
      exp_q.delete(); rx0 = rx_q.size(); dn0 = done_cnt;
      begin_frame(3'd3);
      for (int k = 0; k < 3; k++) send_word(wd(4, k));
      begin_frame(3'd4);
      for (int k = 0; k < 2; k++) send_word(wd(5, k));
      bus.none = 1'b1;
      exp_q.push_back(e_hdr(3'd3));
      exp_q.push_back(e_pay(wd(4, 0)));
      exp_q.push_back(e_pay(wd(4, 1)));
      exp_q.push_back(e_trl(1'b1, 1'b0, 3'd3, 8'd2));
      exp_q.push_back(e_hdr(3'd4));
      exp_q.push_back(e_pay(wd(5, 0)));
      exp_q.push_back(e_pay(wd(5, 1)));
      exp_q.push_back(e_trl(1'b0, 1'b0, 3'd4, 8'd2));
      expect_frames("trunc", 2, rx0, dn0);

      // Empty frame: none right after the event, no data.
      exp_q.delete(); rx0 = rx_q.size(); dn0 = done_cnt;
      begin_frame(3'd5);
      bus.none = 1'b1;
      exp_q.push_back(e_hdr(3'd5));
      exp_q.push_back(e_trl(1'b0, 1'b0, 3'd5, 8'd0));
      expect_frames("empty", 1, rx0, dn0);

      // Reset mid-payload, then input ignored until a fresh event.
      bus.link_ready = 1'b0;
      begin_frame(3'd6);
      for (int k = 0; k < 4; k++) send_word(wd(6, k));
      bus.link_ready = 1'b1;
      repeat (2) step();
      reset              = 1'b0;
      bus.valid          = 1'b1;
      bus.mem_dat_stream = wd(6, 9);
      step();
      check_val("mid_rst_valid", bus.link_valid, 0);
      check_val("mid_rst_dat", bus.link_dat, 0);
      check_val("mid_rst_done", bus.frame_done, 0);
      check_val("mid_rst_fifo_empty", dut.u_fifo.empty, 1);
      reset = 1'b1;
      rx0 = rx_q.size();
      for (int k = 0; k < 3; k++) send_word(wd(7, k));
      repeat (5) step();
      check_val("post_rst_quiet", rx_q.size() - rx0, 0);
      exp_q.delete(); rx0 = rx_q.size(); dn0 = done_cnt;
      begin_frame(3'd7);
      send_word(wd(8, 0));
      bus.none = 1'b1;
      exp_q.push_back(e_hdr(3'd7));
      exp_q.push_back(e_pay(wd(8, 0)));
      exp_q.push_back(e_trl(1'b0, 1'b0, 3'd7, 8'd1));
      expect_frames("post_rst", 1, rx0, dn0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
